vram_arbiter: RTL and testbench

Single-port arbiter and write scheduler for the screen RAM, shared between the active display controller (text or bitmap pixel fetch) and the host register interface (writes and readback). Host writes are buffered in a small FIFO and drained into display-idle cycles. A starvation guard forces a host slot when the display has monopolised the RAM too long. It sits between the mode controllers / host register file and the screen RAM macro, replacing direct dual-port access.

---
 rtl/vga_pkg.sv | 19 +
 rtl/vram_wfifo.sv | 70 +++++++
 rtl/vram_arbiter.sv | 140 ++++++++++++++
 tb/tb_vram_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// vga_pkg : shared VRAM geometry and arbiter grant encoding
// Revision: 1.0
// ============================================================================
package vga_pkg;

    localparam int VRAM_ADDR_W = 16;
    localparam int VRAM_DATA_W = 8;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_DISP = 2'd1,
        G_HRD  = 2'd2,
        G_HWR  = 2'd3
    } grant_t;

endpackage
`default_nettype wire

// File: rtl/vram_wfifo.sv
`default_nettype none
// ============================================================================
// vram_wfifo : host write buffer holding {addr,data} entries
// Revision: 1.0
// ============================================================================
module vram_wfifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic          full,
    output logic          empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [AW+DW-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic [PTR_W:0]   w_count_nxt;
    logic             r_full;
    logic             w_push;
    logic             w_pop;

    // Full is sampled from last cycle, so a same-cycle pop never rescues a push.
    assign w_push = push & ~r_full;
    assign w_pop  = pop & (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (PTR_W+1)'(1);
            2'b01:   w_count_nxt = r_count - (PTR_W+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (PTR_W+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {push_addr, push_data};
    end

    assign {head_addr, head_data} = r_mem[r_rptr];
    assign full  = r_full;
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// vram_arbiter : single-port screen RAM arbiter, display vs buffered host ops
// Revision: 1.0
// ============================================================================
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W      = VRAM_ADDR_W,
    parameter int DATA_W      = VRAM_DATA_W,
    parameter int WFIFO_DEPTH = 4,
    parameter int MAX_WAIT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_waddr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_full,
    output logic              host_ovf,
    input  logic              host_rd,
    input  logic [ADDR_W-1:0] host_raddr,
    output logic              host_rbusy,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    grant_t             w_grant;
    logic               w_fempty;
    logic               w_ffull;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [DATA_W-1:0]  w_head_data;
    logic               w_host_pend;
    logic               w_force;

    logic               r_rd_pend;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_disp_valid;
    logic               r_rvalid;
    logic               r_ovf;
    logic [DATA_W-1:0]  r_rdata_hold;

    vram_wfifo #(
        .DEPTH (WFIFO_DEPTH),
        .AW    (ADDR_W),
        .DW    (DATA_W)
    ) u_wfifo (
        .clk       (clk),
        .rst       (rst),
        .push      (host_wr),
        .push_addr (host_waddr),
        .push_data (host_wdata),
        .pop       (w_grant == G_HWR),
        .head_addr (w_head_addr),
        .head_data (w_head_data),
        .full      (w_ffull),
        .empty     (w_fempty)
    );

    assign w_host_pend = ~w_fempty | r_rd_pend;
    assign w_force     = w_host_pend && (r_wait == WAIT_W'(MAX_WAIT));

    // Reads wait behind buffered writes so readback sees the latest data.
    always_comb begin
        w_grant = G_NONE;
        if (rst)           w_grant = G_NONE;
        else if (w_force)  w_grant = w_fempty ? G_HRD : G_HWR;
        else if (disp_req) w_grant = G_DISP;
        else if (!w_fempty) w_grant = G_HWR;
        else if (r_rd_pend) w_grant = G_HRD;
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (w_grant)
            G_DISP: mem_addr = disp_addr;
            G_HRD:  mem_addr = r_rd_addr;
            G_HWR: begin
                mem_addr  = w_head_addr;
                mem_we    = 1'b1;
                mem_wdata = w_head_data;
            end
            default: mem_addr = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend    <= 1'b0;
            r_rd_addr    <= '0;
            r_wait       <= '0;
            r_disp_valid <= 1'b0;
            r_rvalid     <= 1'b0;
            r_ovf        <= 1'b0;
            r_rdata_hold <= '0;
        end else begin
            r_disp_valid <= (w_grant == G_DISP);
            r_rvalid     <= (w_grant == G_HRD);
            if (host_wr && w_ffull) r_ovf <= 1'b1;
            if (r_rvalid) r_rdata_hold <= mem_rdata;

            if (w_grant == G_HRD) begin
                r_rd_pend <= 1'b0;
            end else if (host_rd && !r_rd_pend) begin
                r_rd_pend <= 1'b1;
                r_rd_addr <= host_raddr;
            end

            if (w_grant == G_HWR || w_grant == G_HRD || !w_host_pend)
                r_wait <= '0;
            else if (w_grant == G_DISP && r_wait != WAIT_W'(MAX_WAIT))
                r_wait <= r_wait + WAIT_W'(1);
        end
    end

    assign disp_gnt    = (w_grant == G_DISP);
    assign disp_valid  = r_disp_valid;
    assign disp_data   = r_disp_valid ? mem_rdata : '0;
    assign host_full   = w_ffull;
    assign host_ovf    = r_ovf;
    assign host_rbusy  = r_rd_pend;
    assign host_rvalid = r_rvalid;
    assign host_rdata  = r_rvalid ? mem_rdata : r_rdata_hold;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_vram_arbiter : randomized + directed bench against a queue-based model
// Revision: 1.0
// ============================================================================
module tb_vram_arbiter;
    import vga_pkg::*;

    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int MAXW  = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_gnt, disp_valid;
    logic [DW-1:0] disp_data;
    logic          host_wr;
    logic [AW-1:0] host_waddr;
    logic [DW-1:0] host_wdata;
    logic          host_full, host_ovf;
    logic          host_rd;
    logic [AW-1:0] host_raddr;
    logic          host_rbusy, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(DEPTH), .MAX_WAIT(MAXW)
    ) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .host_wr(host_wr), .host_waddr(host_waddr), .host_wdata(host_wdata),
        .host_full(host_full), .host_ovf(host_ovf),
        .host_rd(host_rd), .host_raddr(host_raddr), .host_rbusy(host_rbusy),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Screen RAM: synchronous read, unwritten locations return a fixed pattern.
    function automatic logic [7:0] ram_init(input logic [15:0] a);
        return a[7:0] ^ 8'h4A;
    endfunction

    logic [7:0]     ramw [65536];
    bit   [65535:0] wrote;
    always @(posedge clk) begin
        if (mem_we) begin
            ramw[mem_addr]  <= mem_wdata;
            wrote[mem_addr] <= 1'b1;
        end
        mem_rdata <= wrote[mem_addr] ? ramw[mem_addr] : ram_init(mem_addr);
    end

    // ---------------- behavioural model ----------------
    typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
    wr_t        wq[$];
    logic [7:0] sh [65536];
    bit         m_rd_pend, m_ovf, m_dv, m_rv;
    logic [15:0] m_rd_addr;
    logic [7:0] m_dd, m_rdata;
    int         m_wait;
    grant_t     cur_g;
    int         n_vec = 0;
    int         n_err = 0;

    function automatic grant_t model_grant();
        bit pend = (wq.size() != 0) || m_rd_pend;
        if (rst)                    return G_NONE;
        if (pend && m_wait == MAXW) return (wq.size() != 0) ? G_HWR : G_HRD;
        if (disp_req)               return G_DISP;
        if (wq.size() != 0)         return G_HWR;
        if (m_rd_pend)              return G_HRD;
        return G_NONE;
    endfunction

    task automatic model_reset();
        wq.delete();
        m_rd_pend = 0; m_ovf = 0; m_dv = 0; m_rv = 0;
        m_rd_addr = '0; m_dd = '0; m_rdata = '0; m_wait = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic settle();
        logic [15:0] ea;
        #1;
        cur_g = model_grant();
        if (rst) begin
            chk("rst_disp_gnt", disp_gnt, 0);
            chk("rst_disp_valid", disp_valid, 0);
            chk("rst_disp_data", disp_data, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_full", host_full, 0);
            chk("rst_ovf", host_ovf, 0);
            chk("rst_rbusy", host_rbusy, 0);
            chk("rst_rvalid", host_rvalid, 0);
            chk("rst_rdata", host_rdata, 0);
        end else begin
            case (cur_g)
                G_DISP:  ea = disp_addr;
                G_HWR:   ea = wq[0].a;
                G_HRD:   ea = m_rd_addr;
                default: ea = '0;
            endcase
            chk("disp_gnt", disp_gnt, cur_g == G_DISP);
            chk("mem_we", mem_we, cur_g == G_HWR);
            chk("mem_addr", mem_addr, ea);
            if (cur_g == G_HWR) chk("mem_wdata", mem_wdata, wq[0].d);
            chk("host_full", host_full, wq.size() == DEPTH);
            chk("host_ovf", host_ovf, m_ovf);
            chk("host_rbusy", host_rbusy, m_rd_pend);
            chk("disp_valid", disp_valid, m_dv);
            if (m_dv) chk("disp_data", disp_data, m_dd);
            chk("host_rvalid", host_rvalid, m_rv);
            chk("host_rdata", host_rdata, m_rdata);
        end
    endtask

    task automatic advance();
        int sz;
        bit pend, old_rd;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            sz     = wq.size();
            pend   = (sz != 0) || m_rd_pend;
            old_rd = m_rd_pend;
            m_dv   = (cur_g == G_DISP);
            if (m_dv) m_dd = sh[disp_addr];
            m_rv = 0;
            if (cur_g == G_HWR) begin
                sh[wq[0].a] = wq[0].d;
                void'(wq.pop_front());
            end else if (cur_g == G_HRD) begin
                m_rv      = 1;
                m_rdata   = sh[m_rd_addr];
                m_rd_pend = 0;
            end
            if (host_wr) begin
                if (sz == DEPTH) m_ovf = 1;
                else wq.push_back('{a: host_waddr, d: host_wdata});
            end
            if (host_rd && !old_rd) begin
                m_rd_pend = 1;
                m_rd_addr = host_raddr;
            end
            if (cur_g == G_HWR || cur_g == G_HRD || !pend) m_wait = 0;
            else if (cur_g == G_DISP) m_wait++;
        end
        @(negedge clk);
    endtask

    task automatic idle_in();
        disp_req = 0; disp_addr = '0; host_wr = 0; host_waddr = '0;
        host_wdata = '0; host_rd = 0; host_raddr = '0;
    endtask

    initial begin
        int cnt;
        bit seen, we_seen, rv_seen;
        for (int i = 0; i < 65536; i++) sh[i] = ram_init(16'(i));
        model_reset();
        idle_in();
        rst = 1;
        @(negedge clk);
        settle();
        advance();
        advance();
        rst = 0;

        // Idle display: buffered write reaches RAM one cycle after the strobe.
        host_wr = 1; host_waddr = 16'h0123; host_wdata = 8'h41;
        settle(); advance();
        idle_in();
        settle();
        chk("t1_we", mem_we, 1);
        chk("t1_addr", mem_addr, 16'h0123);
        chk("t1_data", mem_wdata, 8'h41);
        chk("t1_full", host_full, 0);
        advance();

        // Display reads: grant each cycle, data one cycle later.
        disp_req = 1; disp_addr = 16'h0010;
        settle(); chk("t2_gnt", disp_gnt, 1); advance();
        settle();
        chk("t2_valid", disp_valid, 1);
        chk("t2_data", disp_data, 8'h5A);
        chk("t2_we", mem_we, 0);
        advance();

        // Starvation guard: one write under continuous display traffic.
        host_wr = 1; host_waddr = 16'h0300; host_wdata = 8'h99;
        settle(); advance();
        host_wr = 0;
        cnt = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            settle();
            if (mem_we) begin
                seen = 1;
                chk("t3_gnt_low", disp_gnt, 0);
                chk("t3_addr", mem_addr, 16'h0300);
            end else if (disp_gnt) cnt++;
            advance();
        end
        chk("t3_seen", seen, 1);
        chk("t3_disp_grants", cnt, 15);

        // Overflow: five writes into a four-entry buffer.
        for (int k = 0; k < 5; k++) begin
            host_wr = 1; host_waddr = 16'h0400 + 16'(k); host_wdata = 8'(k + 1);
            settle();
            if (k == 3) chk("t4_not_full", host_full, 0);
            if (k == 4) chk("t4_full", host_full, 1);
            advance();
        end
        host_wr = 0;
        settle(); chk("t4_ovf", host_ovf, 1); advance();
        disp_req = 0;
        for (int i = 0; i < 10; i++) begin settle(); advance(); end
        settle();
        chk("t4_ovf_sticky", host_ovf, 1);
        chk("t4_drained", host_full, 0);
        advance();

        // Read-after-write ordering on an idle display.
        host_wr = 1; host_waddr = 16'h0200; host_wdata = 8'h77;
        settle(); advance();
        idle_in(); host_rd = 1; host_raddr = 16'h0200;
        settle();
        chk("t5_we", mem_we, 1);
        chk("t5_waddr", mem_addr, 16'h0200);
        advance();
        host_rd = 0;
        settle();
        chk("t5_rbusy", host_rbusy, 1);
        chk("t5_rd_no_we", mem_we, 0);
        chk("t5_raddr", mem_addr, 16'h0200);
        advance();
        settle();
        chk("t5_rvalid", host_rvalid, 1);
        chk("t5_rdata", host_rdata, 8'h77);
        chk("t5_rbusy_fall", host_rbusy, 0);
        advance();

        // Randomized traffic over a small address window.
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 599) == 0);
            disp_req   = ($urandom_range(0, 9) < 7);
            disp_addr  = 16'($urandom_range(0, 63));
            host_wr    = ($urandom_range(0, 9) < 3);
            host_waddr = 16'($urandom_range(0, 63));
            host_wdata = 8'($urandom);
            host_rd    = ($urandom_range(0, 9) < 2);
            host_raddr = 16'($urandom_range(0, 63));
            settle(); advance();
        end
        rst = 0;
        idle_in();
        for (int i = 0; i < 20; i++) begin settle(); advance(); end

        // Reset with three buffered writes and a read outstanding.
        disp_req = 1; disp_addr = 16'h0005;
        for (int k = 0; k < 3; k++) begin
            host_wr = 1; host_waddr = 16'h0500 + 16'(k); host_wdata = 8'hC0 + 8'(k);
            host_rd = (k == 2); host_raddr = 16'h0500;
            settle(); advance();
        end
        host_wr = 0; host_rd = 0;
        settle();
        chk("t6_pre_rbusy", host_rbusy, 1);
        advance();
        rst = 1;
        settle();
        chk("t6_gnt", disp_gnt, 0);
        chk("t6_we", mem_we, 0);
        chk("t6_rbusy", host_rbusy, 0);
        advance();
        rst = 0; disp_req = 0;
        we_seen = 0; rv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (mem_we) we_seen = 1;
            if (host_rvalid) rv_seen = 1;
            advance();
        end
        chk("t6_no_we", we_seen, 0);
        chk("t6_no_rvalid", rv_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
